// File: rtl/mem_interface_unit_pkg.sv
// Shared widths, depth and FSM state encoding for the memory interface unit.
package mem_interface_unit_pkg;

    localparam int unsigned ADDR_W    = 11;
    localparam int unsigned MIU_DEPTH = 2048;
    localparam int unsigned LAT_W     = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESPOND = 2'd2,
        RECOVER = 2'd3
    } miu_state_t;

endpackage

// File: rtl/iu_miu_if.sv
// Request/response link between the instruction unit and the memory interface unit.
interface iu_miu_if #(
    parameter int unsigned ADDR_W = mem_interface_unit_pkg::ADDR_W
) ();

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_write;
    logic [7:0]        mem_read;
    logic              mem_done;

    modport miu (
        input  mem_req, mem_we, mem_addr, mem_write,
        output mem_read, mem_done
    );

    modport iu (
        output mem_req, mem_we, mem_addr, mem_write,
        input  mem_read, mem_done
    );

endinterface

// File: rtl/mem_interface_unit.sv
// Executes byte loads/stores from the instruction unit against a single-port
// synchronous SRAM, flags out-of-range accesses and counts completed accesses.
module mem_interface_unit
    import mem_interface_unit_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = MIU_DEPTH,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              resetN,
    iu_miu_if.miu             miu,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_wdata,
    input  logic [7:0]        sram_rdata,
    output logic              miu_busy_flag,
    output logic              addr_err_flag,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    miu_state_t        state, state_d;
    logic              mem_done_q, mem_done_d;
    logic [7:0]        mem_read_q, mem_read_d;
    logic              sram_en_d, sram_we_d;
    logic [ADDR_W-1:0] sram_addr_d;
    logic [7:0]        sram_wdata_d;
    logic              busy_d, addr_err_d;
    logic [CNT_W-1:0]  rd_count_d, wr_count_d;
    logic [LAT_W-1:0]  lat_cnt, lat_cnt_d;
    logic              we_q, we_q_d;
    logic              err_q, err_q_d;

    assign miu.mem_done = mem_done_q;
    assign miu.mem_read = mem_read_q;

    // Next-state and next-output logic; sram_addr/sram_wdata double as the latched request.
    always_comb begin
        state_d      = state;
        mem_done_d   = 1'b0;
        mem_read_d   = mem_read_q;
        sram_en_d    = 1'b0;
        sram_we_d    = 1'b0;
        sram_addr_d  = sram_addr;
        sram_wdata_d = sram_wdata;
        addr_err_d   = 1'b0;
        rd_count_d   = rd_count;
        wr_count_d   = wr_count;
        lat_cnt_d    = lat_cnt;
        we_q_d       = we_q;
        err_q_d      = err_q;

        case (state)
            IDLE: begin
                if (miu.mem_req) begin
                    we_q_d = miu.mem_we;
                    if (32'(miu.mem_addr) >= MEM_DEPTH) begin
                        err_q_d = 1'b1;
                        state_d = RESPOND;
                    end else begin
                        err_q_d      = 1'b0;
                        sram_en_d    = 1'b1;
                        sram_we_d    = miu.mem_we;
                        sram_addr_d  = miu.mem_addr;
                        sram_wdata_d = miu.mem_write;
                        if (miu.mem_we) begin
                            state_d = RESPOND;
                        end else begin
                            lat_cnt_d = LAT_W'(RD_LAT);
                            state_d   = RD_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: begin
                lat_cnt_d = lat_cnt - LAT_W'(1);
                if (lat_cnt == LAT_W'(1)) begin
                    mem_read_d = sram_rdata;
                    state_d    = RESPOND;
                end
            end
            RESPOND: begin
                mem_done_d = 1'b1;
                addr_err_d = err_q;
                if (err_q) begin
                    if (!we_q) mem_read_d = 8'h00;
                end else if (we_q) begin
                    if (wr_count != {CNT_W{1'b1}}) wr_count_d = wr_count + CNT_W'(1);
                end else begin
                    if (rd_count != {CNT_W{1'b1}}) rd_count_d = rd_count + CNT_W'(1);
                end
                state_d = RECOVER;
            end
            // The initiator may still present the finished request here.
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            mem_done_q    <= 1'b0;
            mem_read_q    <= 8'h00;
            sram_en       <= 1'b0;
            sram_we       <= 1'b0;
            sram_addr     <= '0;
            sram_wdata    <= 8'h00;
            miu_busy_flag <= 1'b0;
            addr_err_flag <= 1'b0;
            rd_count      <= '0;
            wr_count      <= '0;
            lat_cnt       <= '0;
            we_q          <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state         <= state_d;
            mem_done_q    <= mem_done_d;
            mem_read_q    <= mem_read_d;
            sram_en       <= sram_en_d;
            sram_we       <= sram_we_d;
            sram_addr     <= sram_addr_d;
            sram_wdata    <= sram_wdata_d;
            miu_busy_flag <= busy_d;
            addr_err_flag <= addr_err_d;
            rd_count      <= rd_count_d;
            wr_count      <= wr_count_d;
            lat_cnt       <= lat_cnt_d;
            we_q          <= we_q_d;
            err_q         <= err_q_d;
        end
    end

endmodule

// File: tb/tb_mem_interface_unit.sv
// Directed bench: unit A (RD_LAT=1, 2 KiB, 16-bit counters), unit B (RD_LAT=3, 1 KiB, 2-bit counters).
module tb_mem_interface_unit;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    iu_miu_if #(.ADDR_W(11)) ifa ();
    iu_miu_if #(.ADDR_W(11)) ifb ();

    logic        en_a, we_a, busy_a, err_a;
    logic [10:0] addr_a;
    logic [7:0]  wd_a, rd_a;
    logic [15:0] rc_a, wc_a;
    logic        en_b, we_b, busy_b, err_b;
    logic [10:0] addr_b;
    logic [7:0]  wd_b, rd_b;
    logic [1:0]  rc_b, wc_b;

    mem_interface_unit #(.MEM_DEPTH(2048), .RD_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .resetN(resetN), .miu(ifa),
        .sram_en(en_a), .sram_we(we_a), .sram_addr(addr_a), .sram_wdata(wd_a),
        .sram_rdata(rd_a), .miu_busy_flag(busy_a), .addr_err_flag(err_a),
        .rd_count(rc_a), .wr_count(wc_a)
    );

    mem_interface_unit #(.MEM_DEPTH(1024), .RD_LAT(3), .CNT_W(2)) dut_b (
        .clk(clk), .resetN(resetN), .miu(ifb),
        .sram_en(en_b), .sram_we(we_b), .sram_addr(addr_b), .sram_wdata(wd_b),
        .sram_rdata(rd_b), .miu_busy_flag(busy_b), .addr_err_flag(err_b),
        .rd_count(rc_b), .wr_count(wc_b)
    );

    // Behavioural SRAMs: read data is valid in the RD_LAT-th cycle of the held strobe/address.
    logic [7:0] mem_a [0:2047];
    logic [7:0] mem_b [0:1023];
    logic [7:0] pipe_b1, pipe_b2;

    always @(posedge clk) if (en_a && we_a) mem_a[addr_a] <= wd_a;
    assign rd_a = mem_a[addr_a];

    always @(posedge clk) begin
        if (en_b && we_b) mem_b[addr_b[9:0]] <= wd_b;
        pipe_b1 <= mem_b[addr_b[9:0]];
        pipe_b2 <= pipe_b1;
    end
    assign rd_b = pipe_b2;

    int n_tests = 0;
    int n_fail  = 0;

    int          r_lat, r_strobes;
    logic [7:0]  r_data, r_swd;
    logic [10:0] r_saddr;
    logic        r_err, r_swe;

    task automatic drive(input bit sel, input bit req, input bit we,
                         input logic [10:0] addr, input logic [7:0] wd);
        if (sel) begin
            ifb.mem_req = req; ifb.mem_we = we; ifb.mem_addr = addr; ifb.mem_write = wd;
        end else begin
            ifa.mem_req = req; ifa.mem_we = we; ifa.mem_addr = addr; ifa.mem_write = wd;
        end
    endtask

    // One full request/handshake; latency counted from the cycle mem_req is first high.
    task automatic access(input bit sel, input bit we, input logic [10:0] addr,
                          input logic [7:0] wd, input bit toggle);
        logic en, done;
        r_lat = -1; r_strobes = 0; r_data = 8'hxx; r_err = 1'bx;
        r_saddr = 11'h0; r_swd = 8'h00; r_swe = 1'b0;
        @(posedge clk); #1;
        drive(sel, 1'b1, we, addr, wd);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (toggle && c == 1) drive(sel, 1'b1, !we, addr, wd);
            en   = sel ? en_b : en_a;
            done = sel ? ifb.mem_done : ifa.mem_done;
            if (en) begin
                r_strobes++;
                r_saddr = sel ? addr_b : addr_a;
                r_swd   = sel ? wd_b : wd_a;
                r_swe   = sel ? we_b : we_a;
            end
            if (done) begin
                r_lat  = c;
                r_data = sel ? ifb.mem_read : ifa.mem_read;
                r_err  = sel ? err_b : err_a;
                break;
            end
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 11'h0, 8'h00);
    endtask

    task automatic test_reset;
        resetN = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 11'h0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 11'h0, 8'h00);
        repeat (3) @(negedge clk);
        n_tests++;
        if ({ifa.mem_done, en_a, we_a, err_a, busy_a} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags_a: got %b want 00000", {ifa.mem_done, en_a, we_a, err_a, busy_a});
        end
        n_tests++;
        if ({ifa.mem_read, addr_a, wd_a, rc_a, wc_a} !== 59'h0) begin
            n_fail++; $display("FAIL reset_data_a: read=%h addr=%h wd=%h rc=%h wc=%h", ifa.mem_read, addr_a, wd_a, rc_a, wc_a);
        end
        n_tests++;
        if ({ifb.mem_done, en_b, busy_b, ifb.mem_read, rc_b, wc_b} !== 15'h0) begin
            n_fail++; $display("FAIL reset_b: done=%b en=%b busy=%b read=%h rc=%h wc=%h", ifb.mem_done, en_b, busy_b, ifb.mem_read, rc_b, wc_b);
        end
        resetN = 1'b1;
    endtask

    task automatic test_store;
        access(1'b0, 1'b1, 11'h010, 8'hA5, 1'b0);
        n_tests++;
        if (r_lat !== 2) begin n_fail++; $display("FAIL store_latency: got %0d want 2", r_lat); end
        n_tests++;
        if ({r_strobes[3:0], r_swe, r_saddr, r_swd} !== {4'd1, 1'b1, 11'h010, 8'hA5}) begin
            n_fail++; $display("FAIL store_strobe: n=%0d we=%b addr=%h data=%h want 1/1/010/a5", r_strobes, r_swe, r_saddr, r_swd);
        end
        n_tests++;
        if ({wc_a, rc_a, r_data, r_err} !== {16'd1, 16'd0, 8'h00, 1'b0}) begin
            n_fail++; $display("FAIL store_result: wc=%0d rc=%0d read=%h err=%b want 1/0/00/0", wc_a, rc_a, r_data, r_err);
        end
    endtask

    task automatic test_load;
        access(1'b0, 1'b0, 11'h010, 8'h00, 1'b0);
        n_tests++;
        if (r_lat !== 3) begin n_fail++; $display("FAIL load_latency: got %0d want 3", r_lat); end
        n_tests++;
        if ({r_data, r_strobes[3:0], r_swe, r_saddr} !== {8'hA5, 4'd1, 1'b0, 11'h010}) begin
            n_fail++; $display("FAIL load_data: read=%h n=%0d we=%b addr=%h want a5/1/0/010", r_data, r_strobes, r_swe, r_saddr);
        end
        n_tests++;
        if ({rc_a, wc_a} !== {16'd1, 16'd1}) begin
            n_fail++; $display("FAIL load_counts: rc=%0d wc=%0d want 1/1", rc_a, wc_a);
        end
    endtask

    task automatic test_stale_request;
        int extra;
        access(1'b0, 1'b1, 11'h030, 8'h11, 1'b0);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (en_a || ifa.mem_done) extra++;
        end
        n_tests++;
        if (extra !== 0) begin n_fail++; $display("FAIL stale_reaccept: extra activity cycles %0d want 0", extra); end
        n_tests++;
        if ({wc_a, rc_a} !== {16'd2, 16'd1}) begin
            n_fail++; $display("FAIL stale_counts: wc=%0d rc=%0d want 2/1", wc_a, rc_a);
        end
    endtask

    task automatic test_we_toggle;
        access(1'b0, 1'b1, 11'h012, 8'h77, 1'b1);
        n_tests++;
        if ({wc_a, rc_a, r_swe} !== {16'd3, 16'd1, 1'b1}) begin
            n_fail++; $display("FAIL we_toggle_counts: wc=%0d rc=%0d swe=%b want 3/1/1", wc_a, rc_a, r_swe);
        end
        access(1'b0, 1'b0, 11'h012, 8'h00, 1'b0);
        n_tests++;
        if ({r_data, rc_a} !== {8'h77, 16'd2}) begin
            n_fail++; $display("FAIL we_toggle_readback: read=%h rc=%0d want 77/2", r_data, rc_a);
        end
    endtask

    task automatic test_back_to_back;
        access(1'b0, 1'b1, 11'h011, 8'h3C, 1'b0);
        access(1'b0, 1'b0, 11'h011, 8'h00, 1'b0);
        n_tests++;
        if ({r_lat[3:0], r_data, rc_a, wc_a} !== {4'd3, 8'h3C, 16'd3, 16'd4}) begin
            n_fail++; $display("FAIL back_to_back: lat=%0d read=%h rc=%0d wc=%0d want 3/3c/3/4", r_lat, r_data, rc_a, wc_a);
        end
    endtask

    task automatic test_load_lat3;
        access(1'b1, 1'b1, 11'h010, 8'h5A, 1'b0);
        n_tests++;
        if ({r_lat[3:0], wc_b} !== {4'd2, 2'd1}) begin
            n_fail++; $display("FAIL lat3_store: lat=%0d wc=%0d want 2/1", r_lat, wc_b);
        end
        access(1'b1, 1'b0, 11'h010, 8'h00, 1'b0);
        n_tests++;
        if (r_lat !== 5) begin n_fail++; $display("FAIL lat3_load_latency: got %0d want 5", r_lat); end
        n_tests++;
        if ({r_data, rc_b, r_strobes[3:0]} !== {8'h5A, 2'd1, 4'd1}) begin
            n_fail++; $display("FAIL lat3_load_data: read=%h rc=%0d n=%0d want 5a/1/1", r_data, rc_b, r_strobes);
        end
    endtask

    task automatic test_out_of_range;
        access(1'b1, 1'b1, 11'h7FF, 8'hEE, 1'b0);
        n_tests++;
        if ({r_lat[3:0], r_err, r_strobes[3:0], r_data, wc_b} !== {4'd2, 1'b1, 4'd0, 8'h5A, 2'd1}) begin
            n_fail++; $display("FAIL oor_store: lat=%0d err=%b n=%0d read=%h wc=%0d want 2/1/0/5a/1", r_lat, r_err, r_strobes, r_data, wc_b);
        end
        access(1'b1, 1'b0, 11'h400, 8'h00, 1'b0);
        n_tests++;
        if ({r_lat[3:0], r_err, r_strobes[3:0]} !== {4'd2, 1'b1, 4'd0}) begin
            n_fail++; $display("FAIL oor_load: lat=%0d err=%b n=%0d want 2/1/0", r_lat, r_err, r_strobes);
        end
        n_tests++;
        if ({r_data, rc_b, wc_b} !== {8'h00, 2'd1, 2'd1}) begin
            n_fail++; $display("FAIL oor_load_result: read=%h rc=%0d wc=%0d want 00/1/1", r_data, rc_b, wc_b);
        end
        @(negedge clk);
        n_tests++;
        if (err_b !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse: err still %b want 0", err_b); end
    endtask

    task automatic test_reset_mid_read;
        int dones;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 11'h010, 8'h00);
        @(posedge clk); @(posedge clk); #1;
        n_tests++;
        if (busy_b !== 1'b1) begin n_fail++; $display("FAIL midread_busy: got %b want 1", busy_b); end
        resetN = 1'b0;
        #1;
        n_tests++;
        if ({busy_b, en_b, ifb.mem_done, ifb.mem_read, addr_b, rc_b, wc_b} !== 26'h0) begin
            n_fail++; $display("FAIL midread_reset_vals: busy=%b en=%b done=%b read=%h addr=%h rc=%0d wc=%0d", busy_b, en_b, ifb.mem_done, ifb.mem_read, addr_b, rc_b, wc_b);
        end
        drive(1'b1, 1'b0, 1'b0, 11'h0, 8'h00);
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (ifb.mem_done) dones++;
        end
        resetN = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (ifb.mem_done) dones++;
        end
        n_tests++;
        if (dones !== 0) begin n_fail++; $display("FAIL midread_no_done: done pulses %0d want 0", dones); end
        access(1'b1, 1'b0, 11'h010, 8'h00, 1'b0);
        n_tests++;
        if ({r_lat[3:0], r_data, rc_b} !== {4'd5, 8'h5A, 2'd1}) begin
            n_fail++; $display("FAIL midread_recover: lat=%0d read=%h rc=%0d want 5/5a/1", r_lat, r_data, rc_b);
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 5; i++) access(1'b1, 1'b1, 11'(32'h20 + i), 8'(i), 1'b0);
        n_tests++;
        if ({wc_b, rc_b} !== {2'b11, 2'd1}) begin
            n_fail++; $display("FAIL saturation: wc=%b rc=%0d want 11/1", wc_b, rc_b);
        end
        access(1'b1, 1'b0, 11'h024, 8'h00, 1'b0);
        n_tests++;
        if ({r_data, wc_b, rc_b} !== {8'h04, 2'b11, 2'd2}) begin
            n_fail++; $display("FAIL saturation_readback: read=%h wc=%b rc=%0d want 04/11/2", r_data, wc_b, rc_b);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem_a[i] = 8'h00;
        for (int i = 0; i < 1024; i++) mem_b[i] = 8'h00;
        test_reset;
        test_store;
        test_load;
        test_stale_request;
        test_we_toggle;
        test_back_to_back;
        test_load_lat3;
        test_out_of_range;
        test_reset_mid_read;
        test_saturation;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
